// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared constants and types for the loadable instruction memory.
//   OPC_NOP / OPC_HLT : reference opcodes of the 8-bit core (all-zero / all-ones)
//   imem_state_e      : loader state (empty, loading, running)
// No ports; imported by imem_loadable and its sub-modules.
// -----------------------------------------------------------------------------
package imem_pkg;

    localparam logic [7:0] OPC_NOP = 8'h00;
    localparam logic [7:0] OPC_HLT = 8'hFF;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } imem_state_e;

endpackage

// File: rtl/imem_loadable_if.sv
// -----------------------------------------------------------------------------
// imem_loadable_if
// Bundles the program-load port and the fetch port of the instruction memory.
//   master : program loader / core side (drives load_* requests and fetches)
//   slave  : memory side (imem_loadable)
// fetch_err exists only when IMEM_PARITY_EN is defined.
// -----------------------------------------------------------------------------
interface imem_loadable_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic              run;
    logic [ADDR_W:0]   prog_len;
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
`ifdef IMEM_PARITY_EN
    logic              fetch_err;
`endif

    modport master (
        output load_start, load_valid, load_data, load_last, fetch_en, fetch_addr,
        input  load_ready, load_done, run, prog_len, instr, instr_valid
`ifdef IMEM_PARITY_EN
        , input fetch_err
`endif
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last, fetch_en, fetch_addr,
        output load_ready, load_done, run, prog_len, instr, instr_valid
`ifdef IMEM_PARITY_EN
        , output fetch_err
`endif
    );

endinterface

// File: rtl/imem_array.sv
// -----------------------------------------------------------------------------
// imem_array
// Simple dual-port RAM: synchronous write, synchronous registered read, no
// reset. Contents are only meaningful where the owner has written them.
//   clk      : clock
//   we_i     : write enable        waddr_i : write address   wdata_i : write data
//   re_i     : read enable         raddr_i : read address    rdata_o : read data
// rdata_o holds its last value while re_i is low.
// -----------------------------------------------------------------------------
module imem_array #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loadable.sv
// -----------------------------------------------------------------------------
// imem_loadable
// Loadable instruction memory. A program is streamed in over the load port,
// then fetched with one-cycle latency. Any address at or beyond the loaded
// program length reads as HLT, so stale array contents are never executed.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : imem_loadable_if.slave (load port, status, fetch port)
// Optional feature macro: IMEM_PARITY_EN adds an even-parity bit per word and
// the fetch_err output.
// -----------------------------------------------------------------------------
module imem_loadable
    import imem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    imem_loadable_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;
`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [DATA_W-1:0] HLT_WORD = {DATA_W{1'b1}};
    localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

`ifdef IMEM_PARITY_EN
    function automatic logic even_parity_f(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    imem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic              load_done_q, load_done_d;
    logic              fetch_hit_q, fetch_hit_d;
    logic              instr_valid_q;
    logic              load_ready_s, run_s;
    logic              wr_s, end_load_s;
    logic [MEM_W-1:0]  wdata_s, rdata_s;

    // A word is accepted only in LOAD and only when no restart is requested.
    assign wr_s       = (state_q == ST_LOAD) && bus.load_valid && !bus.load_start;
    assign end_load_s = wr_s && (bus.load_last || (wr_ptr_q == LAST_PTR));

`ifdef IMEM_PARITY_EN
    assign wdata_s = {even_parity_f(bus.load_data), bus.load_data};
`else
    assign wdata_s = bus.load_data;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; load_start restarts the load from any state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (bus.load_start) state_d = ST_LOAD;
                else                state_d = ST_EMPTY;
            end
            ST_LOAD: begin
                if (bus.load_start)   state_d = ST_LOAD;
                else if (end_load_s)  state_d = ST_RUN;
                else                  state_d = ST_LOAD;
            end
            ST_RUN: begin
                if (bus.load_start) state_d = ST_LOAD;
                else                state_d = ST_RUN;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // FSM output decode
    always_comb begin
        load_ready_s = 1'b0;
        run_s        = 1'b0;
        case (state_q)
            ST_LOAD: load_ready_s = 1'b1;
            ST_RUN:  run_s        = 1'b1;
            default: begin
                load_ready_s = 1'b0;
                run_s        = 1'b0;
            end
        endcase
    end

    // Next values for write pointer, program length, done pulse and fetch mask
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        if (bus.load_start) begin
            wr_ptr_d   = {ADDR_W{1'b0}};
            prog_len_d = {(ADDR_W + 1){1'b0}};
        end else if (wr_s) begin
            prog_len_d = prog_len_q + LEN_ONE;
            // Pointer saturates on the last slot instead of wrapping.
            if (wr_ptr_q != LAST_PTR) wr_ptr_d = wr_ptr_q + {{(ADDR_W - 1){1'b0}}, 1'b1};
            else                      wr_ptr_d = wr_ptr_q;
        end else begin
            wr_ptr_d   = wr_ptr_q;
            prog_len_d = prog_len_q;
        end
        load_done_d = end_load_s && !bus.load_start;
        // Only in-program RUN fetches see array data; a same-cycle restart masks.
        fetch_hit_d = (state_q == ST_RUN) && !bus.load_start
                      && ({1'b0, bus.fetch_addr} < prog_len_q);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= {ADDR_W{1'b0}};
            prog_len_q    <= {(ADDR_W + 1){1'b0}};
            load_done_q   <= 1'b0;
            fetch_hit_q   <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            prog_len_q    <= prog_len_d;
            load_done_q   <= load_done_d;
            instr_valid_q <= bus.fetch_en;
            // Mask flag holds with the read register so instr holds too.
            if (bus.fetch_en) fetch_hit_q <= fetch_hit_d;
            else              fetch_hit_q <= fetch_hit_q;
        end
    end

    imem_array #(
        .WIDTH  (MEM_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .we_i    (wr_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata_s),
        .re_i    (bus.fetch_en),
        .raddr_i (bus.fetch_addr),
        .rdata_o (rdata_s)
    );

    assign bus.load_ready  = load_ready_s;
    assign bus.run         = run_s;
    assign bus.load_done   = load_done_q;
    assign bus.prog_len    = prog_len_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = fetch_hit_q ? rdata_s[DATA_W-1:0] : HLT_WORD;
`ifdef IMEM_PARITY_EN
    assign bus.fetch_err   = instr_valid_q && fetch_hit_q
                             && (even_parity_f(rdata_s[DATA_W-1:0]) != rdata_s[DATA_W]);
`endif

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, loadable instruction memory for the 8-bit processor, replacing the fixed initial-block program store. A program is streamed in word by word over a valid/ready load port after reset, and the fetch port returns instructions with one-cycle registered latency. Any address not yet written reads as HLT, so the core can never execute stale contents.

## Interface
Parameters:
- DATA_W, 8, instruction width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- load_start  in  1  one-cycle request: enter LOAD, clear write pointer and program length.
- load_valid  in  1  load word present.
- load_data  in  DATA_W  word to write.
- load_last  in  1  qualifies load_data as the final program word.
- load_ready  out  1  high only in LOAD.
- load_done  out  1  one-cycle pulse on the LOAD→RUN transition.
- run  out  1  high in RUN.
- prog_len  out  ADDR_W+1  number of words loaded (0..DEPTH).
- fetch_en  in  1  fetch request.
- fetch_addr  in  ADDR_W  PC.
- instr  out  DATA_W  fetched instruction (registered).
- instr_valid  out  1  high the cycle after an accepted fetch_en.
- fetch_err  out  1  parity error flag (present only with IMEM_PARITY_EN).

## Operation
- States are EMPTY, LOAD and RUN. Reset enters EMPTY.
- EMPTY: load_start→LOAD. Fetches return HLT.
- LOAD:
  - load_ready=1. A load handshake (load_valid&&load_ready) writes mem[wr_ptr] = load_data, then increments wr_ptr and prog_len.
  - If the handshake has load_last=1, or wr_ptr==DEPTH-1, the state moves to RUN and load_done pulses.
  - load_start in LOAD restarts the load: wr_ptr=0, prog_len=0.
- RUN: fetches return mem[fetch_addr] if fetch_addr < prog_len, else HLT (all-ones). load_start→LOAD.
- load_last with load_valid=0 is ignored.
- A load_valid without load_ready (EMPTY/RUN) is dropped with no write.
- If load_start and a handshake occur in the same cycle, load_start wins and the word is discarded.
- If load_start and fetch_en occur in the same RUN cycle, the fetch returns HLT.
- A load_last handshake at wr_ptr==DEPTH-1 gives prog_len=DEPTH. wr_ptr does not wrap.
- Memory array contents are not reset. Masking by prog_len is the only guarantee on their value.

## Timing
- Reset values: state=EMPTY, load_ready=0, load_done=0, run=0, prog_len=0, instr=HLT, instr_valid=0, fetch_err=0.
- Fetch latency is 1 cycle. fetch_en at edge N gives instr/instr_valid after edge N+1. instr holds its value when fetch_en=0, and instr_valid drops.
- Write-then-read to the same address is not possible, because writes occur only outside RUN.
- load_done and run assert after the edge that accepts the last word. The first valid fetch may be issued in that same cycle.
- Reset mid-load returns to EMPTY with prog_len=0. Partial contents are masked.

## Configuration
- IMEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit, computed on write.
  - On a RUN fetch within prog_len, fetch_err is registered alongside instr_valid. It is high if recomputed parity ≠ stored parity. instr still returns the stored data.
  - fetch_err is 0 for masked (HLT) reads.
- Undefined: no parity storage, and the fetch_err port is absent.

## Structure
- imem_pkg: OPC_NOP (all-zero), OPC_HLT (all-ones) constants, and the state enum {ST_EMPTY, ST_LOAD, ST_RUN}.
- Sub-module imem_array: simple dual-port RAM, synchronous write, synchronous registered read, width DATA_W (+1 with parity), depth DEPTH, no reset.
- The top level holds the FSM, wr_ptr, prog_len and the HLT masking mux.

## Test plan
- Reset, then fetch addr 0 in EMPTY → instr=0xFF, instr_valid=1 one cycle later. prog_len=0.
- Load 8 words (NOP, 0x91, 0x12, 0x23, 0x06, 0x07, 0xA4, 0xFF with load_last on the 8th) → load_done pulse, prog_len=8. Fetch 0..7 returns the same words at 1-cycle latency. Fetch 8..15 returns 0xFF.
- Load 16 words without load_last → RUN after the 16th, prog_len=16. Fetch 15 returns the 16th word.
- load_start after 3 words, then load 2 words with last → prog_len=2. Fetch 2 returns 0xFF, even though a word was previously written there.
- rst_n low mid-load after 5 words → outputs at reset values immediately (async). Fetch after reset returns 0xFF.
- With IMEM_PARITY_EN: load 0x12, force one stored data bit flipped via hierarchical access, fetch 0 → fetch_err=1 with instr_valid. An unflipped word gives fetch_err=0.
